cpu_result_logger: RTL and testbench

//  Downstream observer of the CPU core's 16-bit result bus.
//  - Watches the result bus while armed and captures each new value as a {timestamp, result} entry into a FIFO.
//  - Drains the FIFO over a valid/ready stream to a debug/host port.
//  - Sits between the CPU top-level and the debug link; provides non-intrusive execution tracing in silicon and in simulation.

---
 rtl/cpu_result_logger.sv | 191 +++++++++++++++++++
 tb/tb_cpu_result_logger.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_result_logger.sv
// cpu_result_logger
//   Non-intrusive trace logger for the CPU result bus. While armed (RUN) every
//   new result value is captured as a {timestamp, result} entry into a small
//   circular FIFO, which is drained to a debug/host port over valid/ready.
//
//   Build option: define RESULT_LOG_TIMESTAMP_EN to instantiate the free-running
//   cycle timestamp counter; otherwise the timestamp field reads as zero.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   result     in   CPU result bus, sampled every clk
//   start      in   pulse: IDLE/HALT -> RUN
//   stop       in   pulse: RUN -> HALT (wins over start)
//   clear      in   pulse: flush FIFO, clear flags, -> IDLE (highest priority)
//   out_valid  out  FIFO head valid
//   out_ready  in   consumer accepts head when out_valid & out_ready
//   out_data   out  {timestamp, result} of FIFO head, zero when empty
//   level      out  FIFO occupancy 0..DEPTH
//   overflow   out  sticky: at least one capture dropped
//   drop_count out  dropped captures, saturating at 255
//   state      out  00 IDLE, 01 RUN, 10 HALT
module cpu_result_logger #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TS_W   = 16,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         result,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      clear,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [TS_W+DATA_W-1:0]    out_data,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic [7:0]                drop_count,
  output logic [1:0]                state
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned EW = TS_W + DATA_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       wptr_q, wptr_d;
  logic [PW-1:0]       rptr_q, rptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic                ovf_q, ovf_d;
  logic [7:0]          drop_q, drop_d;
  logic [DATA_W-1:0]   last_q, last_d;
  logic                last_vld_q, last_vld_d;
  logic                out_valid_q, out_valid_d;
  logic [EW-1:0]       out_data_q, out_data_d;
  logic [EW-1:0]       mem_q [DEPTH];

  logic                capture, pop, full, push, drop, enter_run;
  logic [PW-1:0]       head_ptr;
  logic                head_avail;
  logic [TS_W-1:0]     ts_cur;

`ifdef RESULT_LOG_TIMESTAMP_EN
  logic [TS_W-1:0]     ts_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts_q <= '0;
    else        ts_q <= ts_q + TS_W'(1);
  end

  assign ts_cur = ts_q;
`else
  assign ts_cur = '0;
`endif

  // Next state: clear > stop > start
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else if (stop) begin
      if (state_q == S_RUN) state_d = S_HALT;
    end else if (start) begin
      if (state_q != S_RUN) state_d = S_RUN;
    end
  end

  always_comb begin
    capture   = (state_q == S_RUN) && (!last_vld_q || (result != last_q));
    pop       = out_valid_q && out_ready;
    full      = (level_q == LW'(DEPTH));
    push      = capture && (!full || pop);
    drop      = capture && full && !pop;
    enter_run = (state_d == S_RUN) && (state_q != S_RUN);

    // The output register presents the head as it stands before this edge's
    // write, so a capture becomes visible one cycle after it is stored. When
    // popping, the next head is the slot after rptr; a same-cycle write to a
    // full FIFO lands in the slot being freed, never in the one read here.
    if (pop) begin
      head_ptr   = rptr_q + PW'(1);
      head_avail = (level_q > LW'(1));
    end else begin
      head_ptr   = rptr_q;
      head_avail = (level_q != '0);
    end

    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    level_d     = level_q;
    ovf_d       = ovf_q;
    drop_d      = drop_q;
    last_d      = last_q;
    last_vld_d  = last_vld_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (clear) begin
      wptr_d      = '0;
      rptr_d      = '0;
      level_d     = '0;
      ovf_d       = 1'b0;
      drop_d      = '0;
      last_vld_d  = 1'b0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      level_d = level_q + LW'(push) - LW'(pop);
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != '1) drop_d = drop_q + 8'd1;
      end
      if (capture) begin
        last_d     = result;
        last_vld_d = 1'b1;
      end
      // Never coincides with capture: capture needs RUN now, entry needs not-RUN.
      if (enter_run) last_vld_d = 1'b0;
      out_valid_d = head_avail;
      out_data_d  = head_avail ? mem_q[head_ptr] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      ovf_q       <= 1'b0;
      drop_q      <= '0;
      last_q      <= '0;
      last_vld_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
      drop_q      <= drop_d;
      last_q      <= last_d;
      last_vld_q  <= last_vld_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Storage needs no reset: entries are only read once the level covers them.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wptr_q] <= {ts_cur, result};
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign level      = level_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;
  assign state      = state_q;

endmodule

// File: tb/tb_cpu_result_logger.sv
// Testbench for cpu_result_logger: directed scenarios plus a randomized phase,
// checked by a queue-based reference model and a negedge monitor/scoreboard.
module tb_cpu_result_logger;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned TS_W   = 16;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned LW     = $clog2(DEPTH) + 1;
  localparam int unsigned EW     = TS_W + DATA_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] result = '0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              clear = 1'b0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [EW-1:0]     out_data;
  logic [LW-1:0]     level;
  logic              overflow;
  logic [7:0]        drop_count;
  logic [1:0]        state;

  cpu_result_logger #(
    .DATA_W(DATA_W),
    .TS_W  (TS_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .result    (result),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .overflow  (overflow),
    .drop_count(drop_count),
    .state     (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: abstract occupancy count, flags and a queue of expected
  // entries in capture order. Modes: 0 IDLE, 1 RUN, 2 HALT.
  int              m_mode = 0;
  int              m_level = 0;
  bit              m_ovf = 0;
  int              m_drops = 0;
  bit              m_valid = 0;
  bit [DATA_W-1:0] m_last = '0;
  bit              m_last_ok = 0;
  bit [TS_W-1:0]   m_ts = '0;
  logic [EW-1:0]   sb[$];

  function automatic logic [TS_W-1:0] ts_field(input bit [TS_W-1:0] t);
`ifdef RESULT_LOG_TIMESTAMP_EN
    return t;
`else
    return '0;
`endif
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_level = 0; m_ovf = 0; m_drops = 0; m_valid = 0;
      m_last_ok = 0; m_ts = '0; sb.delete();
    end else begin
      bit cap, pop;
      int nxt;
      cap = (m_mode == 1) && (!m_last_ok || result != m_last);
      pop = m_valid && out_ready;
      if (clear)      nxt = 0;
      else if (stop)  nxt = (m_mode == 1) ? 2 : m_mode;
      else if (start) nxt = 1;
      else            nxt = m_mode;
      if (clear) begin
        m_level = 0; m_ovf = 0; m_drops = 0; m_valid = 0; sb.delete();
      end else begin
        // An entry stored this cycle is not presented until the next one.
        m_valid = (m_level - int'(pop)) > 0;
        if (cap) begin
          if (m_level == DEPTH && !pop) begin
            m_ovf = 1;
            if (m_drops < 255) m_drops++;
          end else begin
            sb.push_back({ts_field(m_ts), result});
            m_level++;
          end
          m_last = result;
          m_last_ok = 1;
        end
        if (pop) m_level--;
      end
      if (nxt == 1 && m_mode != 1) m_last_ok = 0;
      m_mode = nxt;
      m_ts = m_ts + 1'b1;
    end
  end

  // Monitor: compare the DUT against the model away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      check("state", state, m_mode);
      check("level", level, m_level);
      check("overflow", overflow, m_ovf);
      check("drop_count", drop_count, m_drops);
      check("out_valid", out_valid, m_valid);
      if (!m_valid) check("out_data_empty", out_data, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL pop_no_entry: got out_data=0x%0h expected no pop at %0t", out_data, $time);
        end else begin
          check("out_data", out_data, sb.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_level"}, level, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_drops"}, drop_count, 0);
    check({tag, "_state"}, state, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset, then toggling result in IDLE
    repeat (3) @(posedge clk);
    #2;
    check_zero_outputs("reset");
    reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      result = 16'($urandom);
      tick();
    end
    check("idle_level", level, 0);

    // 2: hold 0x0005 for 4 cycles then 0x0006
    start = 1'b1; tick(); start = 1'b0;
    result = 16'h0005; repeat (4) tick();
    result = 16'h0006; tick();
    repeat (4) tick();

    // 3: overflow with consumer stalled, then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      result = 16'h0100 + 16'(i);
      tick();
    end
    check("ovf_level", level, 8);
    check("ovf_flag", overflow, 1);
    check("ovf_drops", drop_count, 2);
    out_ready = 1'b1;
    repeat (12) tick();
    check("drain_valid", out_valid, 0);
    check("drain_level", level, 0);

    // 4: full, capture and pop in the same cycle
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      result = 16'h0200 + 16'(i);
      tick();
    end
    result = 16'h02FF; out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("fullpop_level", level, 8);
    check("fullpop_drops", drop_count, 2);
    repeat (2) tick();

    // 5: start & stop together in RUN -> HALT; restart recaptures same value
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("halt_state", state, 2);
    result = 16'h0333; out_ready = 1'b1;
    repeat (12) tick();
    check("halt_level", level, 0);
    result = 16'h02FF;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("restart_capture", level, 1);
    repeat (3) tick();

    // 6: clear with level 5 and overflow set
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      result = 16'h0400 + 16'(i);
      tick();
    end
    check("pre_clear_level", level, 5);
    check("pre_clear_ovf", overflow, 1);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clear_level", level, 0);
    check("clear_valid", out_valid, 0);
    check("clear_ovf", overflow, 0);
    check("clear_drops", drop_count, 0);
    check("clear_state", state, 0);

    // Randomized phase over a small value set so repeats occur
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      start = (r < 10);
      stop  = (r >= 10 && r < 15);
      clear = (r == 99);
      result = 16'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    start = 1'b0; stop = 1'b0; clear = 1'b0;

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      result = 16'h0500 + 16'(i);
      tick();
    end
    check("pre_reset_level", level, 3);
    reset = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    @(posedge clk);
    #2;
    reset = 1'b1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
